// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, bubble encoding, default
// fetch addresses and the IF/ID pipeline register payload.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_PC_DEFAULT   = 32'h0000_0100;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

  // RV32I without the C extension needs word-aligned fetch targets.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage : core_pkg

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble and keeps the PC
// fields, hold freezes every field, otherwise the fetched entry is captured.
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush_i,
  input  logic   hold_i,
  input  if_id_t entry_i,
  output if_id_t entry_o
);

  if_id_t entry_q;
  if_id_t entry_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    entry_d = entry_q;
    if (flush_i) begin
      entry_d.valid = 1'b0;
      entry_d.instr = NOP_INSTR;
    end else if (!hold_i) begin
      entry_d = entry_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: pipeline state is a handful of flops, so all of it is reset; sequential state uses <= only.
    if (!rst_n) begin
      entry_q.valid    <= 1'b0;
      entry_q.instr    <= NOP_INSTR;
      entry_q.pc       <= '0;
      entry_q.pc_plus4 <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, PC+4 adder, next-PC selection
// (trap > redirect > stall > sequential) and the IF/ID register.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] TRAP_PC   = TRAP_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic            misalign_err
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic            misalign_q;
  logic            misalign_d;
  if_id_t          fetch_entry;
  if_id_t          if_id_entry;

  assign pc_plus4   = pc_q + 32'd4;  // wraps modulo 2^32
  assign misalign_d = redirect_valid && is_misaligned(redirect_target);

  always_comb begin
    pc_d = pc_plus4;
    if (misalign_d) begin
      pc_d = TRAP_PC;
    end else if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    fetch_entry.valid    = 1'b1;
    fetch_entry.instr    = imem_rdata;
    fetch_entry.pc       = pc_q;
    fetch_entry.pc_plus4 = pc_plus4;
  end

  // A redirect flushes the wrong-path word even when decode is stalled.
  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(redirect_valid),
    .hold_i (stall),
    .entry_i(fetch_entry),
    .entry_o(if_id_entry)
  );

  assign imem_addr      = pc_q;
  assign misalign_err   = misalign_q;
  assign if_id_valid    = if_id_entry.valid;
  assign if_id_instr    = if_id_entry.instr;
  assign if_id_pc       = if_id_entry.pc;
  assign if_id_pc_plus4 = if_id_entry.pc_plus4;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for sequential/stall/redirect/
// trap behaviour, plus reset, PC-wrap and asynchronous-reset sequences.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  logic [31:0] imem_addr,   imem_rdata;
  logic        if_id_valid, misalign_err;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;

  logic [31:0] imem_addr_w, imem_rdata_w;
  logic        if_id_valid_w, misalign_err_w;
  logic [31:0] if_id_instr_w, if_id_pc_w, if_id_pc_plus4_w;

  int checks = 0;
  int errors = 0;

  // Address-tagged instruction memory
  assign imem_rdata   = {16'hC0DE, imem_addr[15:0]};
  assign imem_rdata_w = {16'hC0DE, imem_addr_w[15:0]};

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .misalign_err   (misalign_err)
  );

  fetch_stage #(
    .RESET_PC(32'hFFFF_FFFC)
  ) dut_w (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr_w),
    .imem_rdata     (imem_rdata_w),
    .if_id_valid    (if_id_valid_w),
    .if_id_instr    (if_id_instr_w),
    .if_id_pc       (if_id_pc_w),
    .if_id_pc_plus4 (if_id_pc_plus4_w),
    .misalign_err   (misalign_err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pc"},       imem_addr,            32'h0000_0000);
    check({tag, " valid"},    {31'd0, if_id_valid}, 32'd0);
    check({tag, " instr"},    if_id_instr,          32'h0000_0013);
    check({tag, " if_pc"},    if_id_pc,             32'h0000_0000);
    check({tag, " if_pc4"},   if_id_pc_plus4,       32'h0000_0000);
    check({tag, " err"},      {31'd0, misalign_err}, 32'd0);
    check({tag, " wrap pc"},  imem_addr_w,          32'hFFFF_FFFC);
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ifpc;
    logic [31:0] e_pc4;
    logic        e_err;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                              input logic [31:0] pc, input logic v, input logic [31:0] ins,
                              input logic [31:0] ifpc, input logic [31:0] pc4, input logic err);
    vec_t x;
    x.stall = s; x.rv = r; x.tgt = t;
    x.e_pc = pc; x.e_valid = v; x.e_instr = ins;
    x.e_ifpc = ifpc; x.e_pc4 = pc4; x.e_err = err;
    return x;
  endfunction

  initial begin
    //             stall rv  target     pc          v  instr         if_pc       if_pc4      err
    vecs[0]  = mk(0, 0, 32'h0,   32'h004, 1, 32'hC0DE0000, 32'h000, 32'h004, 0);
    vecs[1]  = mk(0, 0, 32'h0,   32'h008, 1, 32'hC0DE0004, 32'h004, 32'h008, 0);
    vecs[2]  = mk(0, 0, 32'h0,   32'h00C, 1, 32'hC0DE0008, 32'h008, 32'h00C, 0);
    vecs[3]  = mk(0, 0, 32'h0,   32'h010, 1, 32'hC0DE000C, 32'h00C, 32'h010, 0);
    vecs[4]  = mk(1, 0, 32'h0,   32'h010, 1, 32'hC0DE000C, 32'h00C, 32'h010, 0);
    vecs[5]  = mk(1, 0, 32'h0,   32'h010, 1, 32'hC0DE000C, 32'h00C, 32'h010, 0);
    vecs[6]  = mk(1, 0, 32'h0,   32'h010, 1, 32'hC0DE000C, 32'h00C, 32'h010, 0);
    vecs[7]  = mk(0, 0, 32'h0,   32'h014, 1, 32'hC0DE0010, 32'h010, 32'h014, 0);
    vecs[8]  = mk(0, 0, 32'h0,   32'h018, 1, 32'hC0DE0014, 32'h014, 32'h018, 0);
    vecs[9]  = mk(0, 0, 32'h0,   32'h01C, 1, 32'hC0DE0018, 32'h018, 32'h01C, 0);
    vecs[10] = mk(0, 0, 32'h0,   32'h020, 1, 32'hC0DE001C, 32'h01C, 32'h020, 0);
    vecs[11] = mk(0, 1, 32'h200, 32'h200, 0, 32'h00000013, 32'h01C, 32'h020, 0);
    vecs[12] = mk(0, 0, 32'h0,   32'h204, 1, 32'hC0DE0200, 32'h200, 32'h204, 0);
    vecs[13] = mk(1, 1, 32'h040, 32'h040, 0, 32'h00000013, 32'h200, 32'h204, 0);
    vecs[14] = mk(0, 0, 32'h0,   32'h044, 1, 32'hC0DE0040, 32'h040, 32'h044, 0);
    vecs[15] = mk(0, 1, 32'h202, 32'h100, 0, 32'h00000013, 32'h040, 32'h044, 1);
    vecs[16] = mk(0, 0, 32'h0,   32'h104, 1, 32'hC0DE0100, 32'h100, 32'h104, 0);
    vecs[17] = mk(1, 1, 32'h301, 32'h100, 0, 32'h00000013, 32'h100, 32'h104, 1);
    vecs[18] = mk(0, 0, 32'h0,   32'h104, 1, 32'hC0DE0100, 32'h100, 32'h104, 0);
    vecs[19] = mk(0, 1, 32'h202, 32'h100, 0, 32'h00000013, 32'h100, 32'h104, 1);

    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;

    #12;
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      stall           = vecs[i].stall;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      @(posedge clk);
      #1;
      check($sformatf("v%0d pc", i),     imem_addr,             vecs[i].e_pc);
      check($sformatf("v%0d valid", i),  {31'd0, if_id_valid},  {31'd0, vecs[i].e_valid});
      check($sformatf("v%0d instr", i),  if_id_instr,           vecs[i].e_instr);
      check($sformatf("v%0d if_pc", i),  if_id_pc,              vecs[i].e_ifpc);
      check($sformatf("v%0d if_pc4", i), if_id_pc_plus4,        vecs[i].e_pc4);
      check($sformatf("v%0d err", i),    {31'd0, misalign_err}, {31'd0, vecs[i].e_err});
      if (i == 0) begin
        check("wrap pc",     imem_addr_w,      32'h0000_0000);
        check("wrap if_pc",  if_id_pc_w,       32'hFFFF_FFFC);
        check("wrap if_pc4", if_id_pc_plus4_w, 32'h0000_0000);
        check("wrap instr",  if_id_instr_w,    32'hC0DE_FFFC);
      end
    end

    // Asynchronous reset mid-stream, while misalign_err is high
    stall          = 1'b0;
    redirect_valid = 1'b0;
    rst_n          = 1'b0;
    #1;
    check_reset_values("async reset");

    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset pc",     imem_addr,            32'h0000_0004);
    check("post-reset valid",  {31'd0, if_id_valid}, 32'd1);
    check("post-reset if_pc",  if_id_pc,             32'h0000_0000);
    check("post-reset if_pc4", if_id_pc_plus4,       32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_stage
